// File: rtl/kettle_arbiter.sv
// Round-robin arbiter for the shared heater/pump across four kettles.
// Enforces minimum/maximum tenure, a cooldown gap, and sticky timeout faults.
module kettle_arbiter #(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 32,
    parameter int COOLDOWN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic [3:0] fault
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam int KW = $clog2(COOLDOWN + 2);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COOL
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] count;
    logic [KW-1:0] cool;
    logic [1:0]    pick;
    logic [1:0]    cand;
    logic          at_max;
    logic          owner_req;
    logic          release_now;

    // Walk from lowest to highest priority so the nearest requester after ptr wins.
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int i = 4; i >= 1; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) pick = cand;
        end
    end

    assign at_max      = (count == CW'(MAX_HOLD));
    assign owner_req   = req[owner];
    assign release_now = (!owner_req && count >= CW'(MIN_HOLD)) || at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 4'b0000;
            owner   <= 2'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            fault   <= 4'b0000;
            count   <= '0;
            cool    <= '0;
            ptr     <= 2'd3;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        grant <= 4'b0001 << pick;
                        owner <= pick;
                        busy  <= 1'b1;
                        ptr   <= pick;
                        count <= CW'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant <= 4'b0000;
                        busy  <= 1'b0;
                        count <= '0;
                        if (at_max && owner_req) begin
                            timeout      <= 1'b1;
                            fault[owner] <= 1'b1;
                        end
                        if (COOLDOWN == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= COOL;
                            cool  <= KW'(1);
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                COOL: begin
                    if (cool >= KW'(COOLDOWN)) begin
                        state <= IDLE;
                        cool  <= '0;
                    end else begin
                        cool <= cool + KW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kettle_arbiter.sv
// Self-checking bench for kettle_arbiter: directed scenarios plus
// randomized requests compared against a tenure-level reference model.
module tb_kettle_arbiter;

    localparam int MIN_HOLD = 4;
    localparam int MAX_HOLD = 32;
    localparam int COOLDOWN = 2;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic [3:0] fault;

    int vectors = 0;
    int miscompares = 0;

    kettle_arbiter #(
        .MIN_HOLD(MIN_HOLD),
        .MAX_HOLD(MAX_HOLD),
        .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .grant(grant),
        .owner(owner),
        .busy(busy),
        .timeout(timeout),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: who holds the heater, for how long, and how much
    // forced idle time remains, updated from the inputs seen at each edge.
    int       holder = -1;
    int       held = 0;
    int       cool_left = 0;
    int       last = 3;
    logic [3:0] m_fault = 4'b0000;
    logic     m_to = 1'b0;
    logic     m_valid = 1'b0;
    logic     m_cut = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            if (holder >= 0) m_cut = 1'b1;
            holder = -1;
            held = 0;
            cool_left = 0;
            last = 3;
            m_fault = 4'b0000;
            m_to = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_to = 1'b0;
            if (holder >= 0) begin
                if ((!req[holder] && held >= MIN_HOLD) || held == MAX_HOLD) begin
                    if (held == MAX_HOLD && req[holder]) begin
                        m_to = 1'b1;
                        m_fault[holder] = 1'b1;
                    end
                    holder = -1;
                    held = 0;
                    cool_left = COOLDOWN;
                end else begin
                    held++;
                end
            end else if (cool_left > 0) begin
                cool_left--;
            end else if (req != 4'b0000) begin
                int p;
                p = -1;
                for (int k = 1; k <= 4; k++) begin
                    int idx;
                    idx = (last + k) % 4;
                    if (p < 0 && req[idx]) p = idx;
                end
                holder = p;
                last = p;
                held = 1;
            end
        end
    end

    int  run = 0;
    logic prev_b = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            logic [3:0] eg;
            eg = (holder >= 0) ? (4'b0001 << holder) : 4'b0000;
            chk("grant", grant, eg);
            chk("busy", busy, holder >= 0);
            chk("timeout", timeout, m_to);
            chk("fault", fault, m_fault);
            if (holder >= 0) chk("owner", owner, holder);
            chk("onehot0", $onehot0(grant), 1);
            chk("busy_vs_grant", busy, |grant);
            chk("grant_owner_bit", grant[owner], busy);
            if (busy) begin
                run = prev_b ? run + 1 : 1;
            end else if (prev_b) begin
                if (!m_cut)
                    chk("tenure_len", (run >= MIN_HOLD && run <= MAX_HOLD), 1);
                m_cut = 1'b0;
            end
            prev_b = busy;
        end
    end

    int tally;
    int tcount;
    int tpos;
    logic [3:0] g36;
    int owners[$];
    int lens[$];
    int len;
    logic pb;
    int exp_own[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1;
        req = 4'b0000;
        cyc(2);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_owner", owner, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_fault", fault, 4'b0000);

        // Two requesters: kettle 1 first, then kettle 3 after release.
        reset = 1'b0;
        req = 4'b1010;
        cyc(1);
        chk("rr_first", grant, 4'b0010);
        cyc(4);
        req = 4'b1000;
        cyc(1);
        chk("rr_cool1", grant, 4'b0000);
        cyc(2);
        chk("rr_idle", grant, 4'b0000);
        cyc(1);
        chk("rr_second", grant, 4'b1000);
        req = 4'b0000;
        cyc(10);

        // One-cycle pulse still earns the minimum tenure.
        req = 4'b0001;
        tally = 0;
        tcount = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            if (k == 1) req = 4'b0000;
            if (grant == 4'b0001) tally++;
            if (timeout) tcount++;
        end
        chk("pulse_hold", tally, MIN_HOLD);
        chk("pulse_timeout", tcount, 0);
        chk("pulse_fault", fault, 4'b0000);

        // Held request runs into the maximum tenure.
        req = 4'b0001;
        tally = 0;
        tcount = 0;
        tpos = 0;
        g36 = 4'b0000;
        for (int k = 1; k <= 36; k++) begin
            cyc(1);
            if (k <= 35 && grant == 4'b0001) tally++;
            if (timeout) begin
                tcount++;
                tpos = k;
            end
            if (k == 36) g36 = grant;
        end
        chk("max_hold", tally, MAX_HOLD);
        chk("max_timeout_cnt", tcount, 1);
        chk("max_timeout_pos", tpos, MAX_HOLD + 1);
        chk("max_regrant", g36, 4'b0001);
        chk("max_fault", fault, 4'b0001);
        req = 4'b0000;
        cyc(10);

        // Reset in the middle of a tenure.
        req = 4'b1111;
        cyc(1);
        chk("mid_owner", grant, 4'b0010);
        cyc(9);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_grant", grant, 4'b0000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_fault", fault, 4'b0000);
        reset = 1'b0;
        req = 4'b0110;
        cyc(1);
        chk("mid_regrant", grant, 4'b0010);
        req = 4'b0000;
        cyc(10);

        // Everyone requesting: full rotation with every tenure timing out.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        req = 4'b1111;
        pb = 1'b0;
        len = 0;
        for (int k = 0; k < 200; k++) begin
            cyc(1);
            if (busy && !pb) begin
                owners.push_back(int'(owner));
                len = 0;
            end
            if (busy) len++;
            if (!busy && pb) lens.push_back(len);
            pb = busy;
        end
        chk("rot_count", owners.size() >= 5, 1);
        for (int i = 0; i < 5; i++)
            if (i < owners.size()) chk("rot_owner", owners[i], exp_own[i]);
        for (int i = 0; i < 4; i++)
            if (i < lens.size()) chk("rot_len", lens[i], MAX_HOLD);
        chk("rot_fault", fault, 4'b1111);

        // Random traffic: slowly flipping request bits and rare resets.
        for (int k = 0; k < 3000; k++) begin
            cyc(1);
            reset = ($urandom_range(0, 499) == 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 19) == 0) req[b] = ~req[b];
        end
        reset = 1'b0;
        req = 4'b0000;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
